// File: rtl/serial_dac_pkg.sv
// Shared types and constants for the dual-lane serial DAC frame receiver.
// Frame layout: {cmd[3:0], addr[3:0], data[DATA_W-1:0]}, sent MSB first.
package serial_dac_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FRAME_BITS = 24;

  typedef logic [3:0]            cmd_t;
  typedef logic [3:0]            addr_t;
  typedef logic [DEF_DATA_W-1:0] data_t;

  typedef struct packed {
    cmd_t  cmd;
    addr_t addr;
    data_t data;
  } frame_t;

  localparam cmd_t CMD_NOP    = 4'h0;
  localparam cmd_t CMD_WR_IN  = 4'h1;
  localparam cmd_t CMD_UPD    = 4'h2;
  localparam cmd_t CMD_WR_UPD = 4'h3;

  localparam addr_t ADDR_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK
  } lane_st_e;

  function automatic logic frame_legal(
    input cmd_t  c,
    input addr_t a,
    input int    num_ch
  );
    return (c <= CMD_WR_UPD) &&
           ((a == ADDR_ALL) || (int'(a) < num_ch));
  endfunction

endpackage

// File: rtl/serial_lane_rx.sv
// One SPI lane deserializer: shifts bits on detected spi_clk rises and
// qualifies the frame when chip select returns high.
module serial_lane_rx
  import serial_dac_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cs_fall_i,
  input  logic                  cs_rise_i,
  input  logic                  spi_rise_i,
  input  logic                  sdi_i,
  input  logic                  abort_i,
  output logic [FRAME_BITS-1:0] frame_word_o,
  output logic                  frame_valid_o,
  output logic                  frame_err_o
);

  localparam int CW = $clog2(FRAME_BITS + 1);

  lane_st_e              state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] word_q;
  logic [CW-1:0]         cnt_q;
  logic                  ovr_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  legal_w;
  logic                  full_w;

  assign legal_w = frame_legal(shift_q[FRAME_BITS-1 -: 4],
                               shift_q[FRAME_BITS-5 -: 4],
                               NUM_CH);
  assign full_w  = (cnt_q == CW'(FRAME_BITS));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      // DAC soft reset silently drops whatever was in flight
      if (abort_i) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (cs_fall_i) begin
              shift_q <= '0;
              cnt_q   <= '0;
              ovr_q   <= 1'b0;
              state_q <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (spi_rise_i) begin
              if (full_w) begin
                ovr_q <= 1'b1;
              end else begin
                shift_q <= {shift_q[FRAME_BITS-2:0], sdi_i};
                cnt_q   <= cnt_q + 1'b1;
              end
            end
            if (cs_rise_i) begin
              state_q <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (full_w && !ovr_q && legal_w) begin
              valid_q <= 1'b1;
              word_q  <= shift_q;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign frame_word_o  = word_q;
  assign frame_valid_o = valid_q;
  assign frame_err_o   = err_q;

endmodule

// File: rtl/serial_dac_frame_rx.sv
// Dual-lane serial DAC receiver modelling the DAC input/output register map.
// Optional SERIAL_DAC_FRAME_CNT_EN adds per-lane accepted-frame counters.
module serial_dac_frame_rx
  import serial_dac_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic                         sysclk,
  input  logic                         reset,
  input  logic                         cs_n_i,
  input  logic                         spi_clk_i,
  input  logic                         sdi0_i,
  input  logic                         sdi1_i,
  input  logic                         ldac_n_i,
  input  logic                         reset_dac_i,
  output logic [2*NUM_CH*DATA_W-1:0]   dac_code_o,
  output logic [1:0]                   frame_valid_o,
  output logic [2*FRAME_BITS-1:0]      frame_word_o,
  output logic [1:0]                   frame_err_o
`ifdef SERIAL_DAC_FRAME_CNT_EN
  ,
  output logic [31:0]                  frame_cnt_o
`endif
);

  // bit order: cs, spi, sdi0, sdi1, ldac, reset_dac
  logic [5:0] in_w;
  logic [5:0] s1_q;
  logic [5:0] s2_q;
  logic [5:0] prev_q;

  assign in_w = {reset_dac_i, ldac_n_i, sdi1_i,
                 sdi0_i, spi_clk_i, cs_n_i};

  // Idle-low reset values keep a held-low cs/ldac from looking like a fall
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= in_w;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  logic cs_fall_w;
  logic cs_rise_w;
  logic spi_rise_w;
  logic ldac_fall_w;
  logic rdac_w;

  assign cs_fall_w   = ~s2_q[0] &  prev_q[0];
  assign cs_rise_w   =  s2_q[0] & ~prev_q[0];
  assign spi_rise_w  =  s2_q[1] & ~prev_q[1];
  assign ldac_fall_w = ~s2_q[4] &  prev_q[4];
  assign rdac_w      =  s2_q[5];

  logic [1:0][FRAME_BITS-1:0] word_w;
  logic [1:0]                 valid_w;
  logic [1:0]                 err_w;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    serial_lane_rx #(
      .NUM_CH     (NUM_CH),
      .FRAME_BITS (FRAME_BITS)
    ) u_lane (
      .clk_i         (sysclk),
      .rst_i         (reset),
      .cs_fall_i     (cs_fall_w),
      .cs_rise_i     (cs_rise_w),
      .spi_rise_i    (spi_rise_w),
      .sdi_i         (s2_q[2+g]),
      .abort_i       (rdac_w),
      .frame_word_o  (word_w[g]),
      .frame_valid_o (valid_w[g]),
      .frame_err_o   (err_w[g])
    );
  end

  logic [1:0][NUM_CH-1:0][DATA_W-1:0] in_q;
  logic [1:0][NUM_CH-1:0][DATA_W-1:0] in_d;
  logic [1:0][NUM_CH-1:0][DATA_W-1:0] out_q;
  logic [1:0][NUM_CH-1:0][DATA_W-1:0] out_d;

  always_comb begin
    cmd_t              cmd;
    addr_t             addr;
    logic [DATA_W-1:0] data;
    in_d  = in_q;
    out_d = out_q;
    cmd   = CMD_NOP;
    addr  = '0;
    data  = '0;
    for (int l = 0; l < 2; l++) begin
      cmd  = word_w[l][FRAME_BITS-1 -: 4];
      addr = word_w[l][FRAME_BITS-5 -: 4];
      data = word_w[l][DATA_W-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (valid_w[l] &&
            (addr == ADDR_ALL || addr == addr_t'(c))) begin
          case (cmd)
            CMD_WR_IN: in_d[l][c] = data;
            CMD_UPD:   out_d[l][c] = in_q[l][c];
            CMD_WR_UPD: begin
              in_d[l][c]  = data;
              out_d[l][c] = data;
            end
            default: ;
          endcase
        end
      end
    end
    // LDAC transfers the post-write input value
    if (ldac_fall_w) begin
      out_d = in_d;
    end
    if (rdac_w) begin
      in_d  = '0;
      out_d = '0;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      in_q  <= '0;
      out_q <= '0;
    end else begin
      in_q  <= in_d;
      out_q <= out_d;
    end
  end

`ifdef SERIAL_DAC_FRAME_CNT_EN
  logic [1:0][15:0] cnt_q;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (rdac_w) begin
      cnt_q <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (valid_w[l]) begin
          cnt_q[l] <= cnt_q[l] + 16'd1;
        end
      end
    end
  end

  assign frame_cnt_o = cnt_q;
`endif

  assign dac_code_o    = out_q;
  assign frame_valid_o = valid_w;
  assign frame_word_o  = word_w;
  assign frame_err_o   = err_w;

endmodule

// File: tb/tb_serial_dac_frame_rx.sv
// Randomized bench for serial_dac_frame_rx against an array-based register map model.
// Build with SERIAL_DAC_FRAME_CNT_EN to also check the frame counters.
module tb_serial_dac_frame_rx;

  logic         sysclk = 1'b0;
  logic         reset = 1'b1;
  logic         cs_n = 1'b1;
  logic         spi = 1'b0;
  logic         sdi0 = 1'b0;
  logic         sdi1 = 1'b0;
  logic         ldac_n = 1'b1;
  logic         rdac = 1'b0;
  logic [127:0] dac_code_o;
  logic [1:0]   frame_valid_o;
  logic [47:0]  frame_word_o;
  logic [1:0]   frame_err_o;
`ifdef SERIAL_DAC_FRAME_CNT_EN
  logic [31:0]  frame_cnt_o;
`endif

  serial_dac_frame_rx dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .cs_n_i        (cs_n),
    .spi_clk_i     (spi),
    .sdi0_i        (sdi0),
    .sdi1_i        (sdi1),
    .ldac_n_i      (ldac_n),
    .reset_dac_i   (rdac),
    .dac_code_o    (dac_code_o),
    .frame_valid_o (frame_valid_o),
    .frame_word_o  (frame_word_o),
    .frame_err_o   (frame_err_o)
`ifdef SERIAL_DAC_FRAME_CNT_EN
    ,
    .frame_cnt_o   (frame_cnt_o)
`endif
  );

  always #10 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference register map
  logic [15:0] m_in  [2][4];
  logic [15:0] m_out [2][4];
  logic [23:0] m_word[2];
  int          m_v[2];
  int          m_e[2];
  int          m_cnt[2];
  int          o_v[2];
  int          o_e[2];

  always @(negedge sysclk) begin
    for (int l = 0; l < 2; l++) begin
      if (frame_valid_o[l]) o_v[l]++;
      if (frame_err_o[l]) o_e[l]++;
    end
  end

  function automatic void mframe(input int l, input logic [23:0] w,
                                 input int nbits);
    logic [3:0]  c = w[23:20];
    logic [3:0]  a = w[19:16];
    logic [15:0] d = w[15:0];
    bit ok = (nbits == 24) && (c <= 3) && (a == 15 || a < 4);
    if (!ok) begin
      m_e[l]++;
      return;
    end
    m_v[l]++;
    m_word[l] = w;
    m_cnt[l] = (m_cnt[l] + 1) % 65536;
    for (int ch = 0; ch < 4; ch++) begin
      if (a == 15 || a == ch) begin
        if (c == 1 || c == 3) m_in[l][ch] = d;
        if (c == 3) m_out[l][ch] = d;
        else if (c == 2) m_out[l][ch] = m_in[l][ch];
      end
    end
  endfunction

  function automatic void mldac();
    for (int l = 0; l < 2; l++)
      for (int ch = 0; ch < 4; ch++) m_out[l][ch] = m_in[l][ch];
  endfunction

  function automatic void mclear(input bit words);
    for (int l = 0; l < 2; l++) begin
      for (int ch = 0; ch < 4; ch++) begin
        m_in[l][ch]  = '0;
        m_out[l][ch] = '0;
      end
      m_cnt[l] = 0;
      if (words) m_word[l] = '0;
    end
  endfunction

  function automatic logic [127:0] exp_code();
    logic [127:0] r = '0;
    for (int l = 0; l < 2; l++)
      for (int ch = 0; ch < 4; ch++) r[(l*4+ch)*16 +: 16] = m_out[l][ch];
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":code"}, dac_code_o, exp_code());
    chk({tag, ":v0"}, 128'(o_v[0]), 128'(m_v[0]));
    chk({tag, ":v1"}, 128'(o_v[1]), 128'(m_v[1]));
    chk({tag, ":e0"}, 128'(o_e[0]), 128'(m_e[0]));
    chk({tag, ":e1"}, 128'(o_e[1]), 128'(m_e[1]));
    chk({tag, ":word"}, 128'(frame_word_o), 128'({m_word[1], m_word[0]}));
`ifdef SERIAL_DAC_FRAME_CNT_EN
    chk({tag, ":cnt"}, 128'(frame_cnt_o),
        128'({m_cnt[1][15:0], m_cnt[0][15:0]}));
`endif
  endtask

  task automatic bit_clk(input logic b0, input logic b1);
    sdi0 = b0;
    sdi1 = b1;
    spi = 1'b0;
    repeat (4) @(negedge sysclk);
    spi = 1'b1;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic send(input logic [23:0] w0, input logic [23:0] w1,
                      input int nbits, input int abort_at,
                      input int ldac_dly, input bit tcheck,
                      input logic [127:0] pre, input logic [127:0] post);
    int k;
    @(negedge sysclk);
    cs_n = 1'b0;
    repeat (4) @(negedge sysclk);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        rdac = 1'b1;
        repeat (6) @(negedge sysclk);
        rdac = 1'b0;
        repeat (4) @(negedge sysclk);
      end
      bit_clk(i < 24 ? w0[23-i] : 1'b0, i < 24 ? w1[23-i] : 1'b0);
    end
    spi = 1'b0;
    repeat (4) @(negedge sysclk);
    cs_n = 1'b1;
    if (tcheck) begin
      k = 0;
      while (!frame_valid_o[0] && k < 20) begin
        @(negedge sysclk);
        k++;
      end
      chk("valid_seen", 128'(frame_valid_o[0]), 128'(1));
      chk("pre_update", dac_code_o, pre);
      @(negedge sysclk);
      chk("post_update", dac_code_o, post);
    end
    if (ldac_dly >= 0) begin
      repeat (ldac_dly) @(negedge sysclk);
      ldac_n = 1'b0;
      repeat (4) @(negedge sysclk);
      ldac_n = 1'b1;
    end
    repeat (12) @(negedge sysclk);
  endtask

  task automatic frame(input logic [23:0] w0, input logic [23:0] w1,
                       input int nbits);
    mframe(0, w0, nbits);
    mframe(1, w1, nbits);
    send(w0, w1, nbits, -1, -1, 1'b0, '0, '0);
  endtask

  task automatic ldac_pulse();
    logic [127:0] pre;
    logic [127:0] post;
    pre = exp_code();
    mldac();
    post = exp_code();
    @(negedge sysclk);
    ldac_n = 1'b0;
    @(negedge sysclk);
    chk("ldac_pre", dac_code_o, pre);
    repeat (3) @(negedge sysclk);
    chk("ldac_post", dac_code_o, post);
    ldac_n = 1'b1;
    repeat (8) @(negedge sysclk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] pre;
    logic [127:0] post;
    logic [23:0]  w[2];
    int           nb;
    mclear(1'b1);
    for (int l = 0; l < 2; l++) begin
      m_v[l] = 0; m_e[l] = 0; o_v[l] = 0; o_e[l] = 0;
    end

    repeat (3) @(negedge sysclk);
    chk("rst_code", dac_code_o, '0);
    chk("rst_word", 128'(frame_word_o), '0);
    chk("rst_pulse", 128'({frame_valid_o, frame_err_o}), '0);
    reset = 1'b0;
    repeat (4) @(negedge sysclk);

    pre = exp_code();
    mframe(0, 24'h31ABCD, 24);
    mframe(1, 24'h000000, 24);
    post = exp_code();
    send(24'h31ABCD, 24'h000000, 24, -1, -1, 1'b1, pre, post);
    check_all("wr_upd");

    frame(24'h121234, 24'h105555, 24);
    check_all("staged");
    ldac_pulse();
    check_all("ldac");

    frame(24'h000000, 24'h3F00FF, 24);
    check_all("bcast");

    frame(24'h320001, 24'h320002, 20);
    check_all("short");
    frame(24'h320001, 24'h320002, 26);
    check_all("long");
    frame(24'h701111, 24'h000000, 24);
    check_all("badcmd");
    frame(24'h000000, 24'h152222, 24);
    check_all("badaddr");
    frame(24'h000000, 24'h000000, 0);
    check_all("empty");

    frame(24'h101111, 24'h000000, 24);
    mframe(0, 24'h10AAAA, 24);
    mframe(1, 24'h000000, 24);
    mldac();
    send(24'h10AAAA, 24'h000000, 24, -1, 2, 1'b0, '0, '0);
    check_all("collide");

    mclear(1'b0);
    send(24'h317777, 24'h328888, 24, 10, -1, 1'b0, '0, '0);
    check_all("rdac_abort");
    frame(24'h304321, 24'h33BEEF, 24);
    check_all("after_abort");

    @(negedge sysclk);
    cs_n = 1'b0;
    repeat (4) @(negedge sysclk);
    for (int i = 0; i < 8; i++) bit_clk(i[0], 1'b0);
    reset = 1'b1;
    #1;
    chk("arst_code", dac_code_o, '0);
    chk("arst_word", 128'(frame_word_o), '0);
    chk("arst_pulse", 128'({frame_valid_o, frame_err_o}), '0);
    mclear(1'b1);
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    for (int i = 8; i < 24; i++) bit_clk(i[0], 1'b1);
    spi = 1'b0;
    repeat (4) @(negedge sysclk);
    cs_n = 1'b1;
    repeat (12) @(negedge sysclk);
    check_all("arst_after");

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: nb = 20;
        1: nb = 26;
        2: nb = 0;
        default: nb = 24;
      endcase
      for (int l = 0; l < 2; l++) begin
        w[l][23:20] = ($urandom_range(0, 4) == 0) ?
                      4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
          4: w[l][19:16] = 4'hF;
          5: w[l][19:16] = 4'($urandom_range(4, 14));
          default: w[l][19:16] = 4'($urandom_range(0, 3));
        endcase
        w[l][15:0] = 16'($urandom);
      end
      frame(w[0], w[1], nb);
      check_all("rand");
      if ($urandom_range(0, 3) == 0) begin
        ldac_pulse();
        check_all("rand_ldac");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_dac_frame_rx.md
Name: serial_dac_frame_rx

Overview:
- DAC-side receiver for the dual-lane SPI stream produced by the serial DAC driver: CS, spi_clk, two data lanes, LDAC and DAC reset.
- Oversamples the serial inputs in the sysclk domain and deserializes one 24-bit frame per lane.
- Decodes each frame's command into per-channel input and output registers, modelling the DAC register map.
- Used for FPGA loopback self-check and as a synthesizable bench responder.

Parameters:
- NUM_CH, 4: DAC channels per lane.
- DATA_W, 16: code width per channel.
- FRAME_BITS, 24: bits per frame (4 cmd + 4 addr + DATA_W).

Ports:
- sysclk  in  1  system clock; must be at least 4x spi_clk_i.
- reset  in  1  asynchronous, active-high reset.
- cs_n_i  in  1  chip select, active low.
- spi_clk_i  in  1  serial clock.
- sdi0_i  in  1  lane 0 serial data.
- sdi1_i  in  1  lane 1 serial data.
- ldac_n_i  in  1  load DAC, active low.
- reset_dac_i  in  1  DAC soft reset, active high.
- dac_code_o  out  2*NUM_CH*DATA_W  output registers, flattened: lane-major, channel 0 at LSBs.
- frame_valid_o  out  2  per-lane 1-cycle pulse when a complete frame is accepted.
- frame_word_o  out  2*FRAME_BITS  last accepted frame per lane.
- frame_err_o  out  2  per-lane 1-cycle pulse on short, long or illegal frame.

Behaviour:
- Input sync: 2-flop synchronizers on all six serial inputs.
- Edge detection runs on the synchronized signals, so input-to-detect latency is 3 sysclk.
- Bit capture: on a spi_clk rising edge while cs_n low, shift the sdi bit in MSB-first; bit counter 0..FRAME_BITS.
- Per-lane FSM:
  - IDLE: on cs_n falling edge, clear shift register and counter; go to SHIFT.
  - SHIFT: shift on each spi_clk rise. When the counter reaches FRAME_BITS, further edges are not shifted and set an overrun flag. On cs_n rising edge go to CHECK.
  - CHECK (1 cycle): if count == FRAME_BITS, no overrun and the command is legal, pulse frame_valid_o and latch frame_word_o. Otherwise pulse frame_err_o, discard the frame and leave the registers untouched. Return to IDLE.
- Frame format: [23:20] cmd, [19:16] addr, [15:0] data.
- Command 0x0: NOP; valid, no register effect.
- Command 0x1: write input register [addr].
- Command 0x2: copy input register [addr] to output register [addr].
- Command 0x3: write input register [addr] and the output register [addr] in the same cycle.
- Addressing: addr 0xF targets all channels. Any other addr >= NUM_CH is an illegal frame. All other cmd values are illegal.
- Register updates take effect the cycle after CHECK, i.e. dac_code_o changes exactly 1 cycle after frame_valid_o.
- LDAC: on a synchronized ldac_n falling edge, all input registers of both lanes are copied to the output registers.
- LDAC coinciding with a register write: the new input value is the one transferred.
- reset_dac_i high (level, synchronized): all input and output registers are forced to 0. An in-flight frame is aborted to IDLE without an error pulse.
- cs_n rising edge with 0 bits captured: treated as a short frame, so frame_err_o pulses.
- cs_n low during reset release: the FSM stays in IDLE until the next cs_n falling edge.
- Reset values: all registers 0, dac_code_o 0, frame_word_o 0, pulses 0, FSM IDLE.

Optional Feature:
- Macro: SERIAL_DAC_FRAME_CNT_EN.
- When defined: adds output port frame_cnt_o, 2x16 bits, a per-lane count of accepted frames. It wraps 0xFFFF->0, clears on reset and on reset_dac_i, and does not count errored frames.
- When undefined: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_dac_pkg:
  - CMD_NOP, CMD_WR_IN, CMD_UPD, CMD_WR_UPD.
  - ADDR_ALL = 4'hF.
  - FRAME_BITS and DATA_W defaults.
  - Typedefs for the frame fields (cmd, addr, data).
- Sub-module serial_lane_rx, instantiated twice: synchronized edge inputs plus one sdi lane in, frame word plus valid/err pulses out.
- The top level owns the synchronizers, edge detection, register files, LDAC and reset_dac handling.

Test Plan:
- Single write-and-update: lane0 frame 0x3_1_ABCD, sysclk 50 MHz, spi 6.25 MHz -> frame_valid_o[0] pulses once; lane 0 channel 1 output = 0xABCD the next cycle; all other channels stay 0.
- Staged update via LDAC: lane0 0x1_2_1234 and lane1 0x1_0_5555, outputs unchanged; then ldac_n pulse low -> lane0 ch2 = 0x1234 and lane1 ch0 = 0x5555, 3-4 cycles after the falling edge.
- Broadcast: lane1 0x3_F_00FF -> all four lane-1 output registers = 0x00FF; lane 0 unchanged.
- Short, long and illegal frames:
  - 20-bit frame -> frame_err_o pulses, no register change.
  - 26-bit frame -> frame_err_o pulses, no register change.
  - cmd 0x7 -> frame_err_o pulses, no register change.
  - addr 0x5 -> frame_err_o pulses, no register change.
- Abort and reset:
  - reset_dac_i asserted mid-frame (bit 10) -> all outputs return to 0, no err pulse; the next full frame is accepted normally.
  - Async reset asserted mid-frame -> immediate reset values.
- Collision: ldac_n falling edge in the same cycle as the register update of 0x1_0_AAAA -> output ch0 = 0xAAAA.
- With SERIAL_DAC_FRAME_CNT_EN defined: 3 good frames plus 1 bad frame -> frame_cnt_o lane count = 3.
